ps2_key_fifo: RTL and testbench

PS2_KEY_FIFO -- requirements
Module: ps2_key_fifo

---
 rtl/ps2_key_fifo_if.sv | 25 ++
 rtl/ps2_key_fifo.sv | 154 +++++++++++++++
 tb/tb_ps2_key_fifo.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_fifo_if.sv
// Interface bundle for the PS/2 key FIFO. It carries the scan-code input,
// the consumer pop request and the character/status outputs.
interface ps2_key_fifo_if;
  logic [7:0] PS2_code;
  logic       PS2_code_ready;
  logic       char_rd_en;
  logic [7:0] char_data;
  logic       char_empty;
  logic       char_full;
  logic [4:0] char_count;
  logic       char_overflow;
  logic       shift_active;

  // Producer/consumer side: drives codes and pops, observes the FIFO.
  modport master (
    output PS2_code, PS2_code_ready, char_rd_en,
    input  char_data, char_empty, char_full, char_count, char_overflow, shift_active
  );

  // Block side.
  modport slave (
    input  PS2_code, PS2_code_ready, char_rd_en,
    output char_data, char_empty, char_full, char_count, char_overflow, shift_active
  );
endinterface

// File: rtl/ps2_key_fifo.sv
// PS/2 set-2 scan-code decoder feeding an ASCII character FIFO.
// Break/extended prefixes are tracked by a small FSM, shift keys are held in
// two flags, and printable make codes are pushed into a circular buffer.
module ps2_key_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input logic          Clock_50,
  input logic          Resetn,
  ps2_key_fifo_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [4:0] DEPTH5 = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_KEY_IDLE, S_KEY_BREAK, S_KEY_EXT, S_KEY_EXT_BREAK} key_state_t;

  key_state_t state_q, state_d;
  logic       ready_q, code_evt;
  logic       left_shift, right_shift, ls_d, rs_d;
  logic       push_req;
  logic [7:0] push_char;
  logic       is_letter, is_sym;
  logic [4:0] letter_idx;
  logic [7:0] sym_char;

  logic [FIFO_DEPTH-1:0][7:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    count;
  logic          overflow;
  logic          do_push, do_pop, full, empty;

  // One event per rising edge of the ready level.
  assign code_evt = bus.PS2_code_ready & ~ready_q;

  // Scan-code lookup: letters as an alphabet index, other mapped keys as ASCII.
  always_comb begin
    is_letter  = 1'b1;
    letter_idx = 5'd0;
    case (bus.PS2_code)
      8'h1C: letter_idx = 5'd0;   8'h32: letter_idx = 5'd1;
      8'h21: letter_idx = 5'd2;   8'h23: letter_idx = 5'd3;
      8'h24: letter_idx = 5'd4;   8'h2B: letter_idx = 5'd5;
      8'h34: letter_idx = 5'd6;   8'h33: letter_idx = 5'd7;
      8'h43: letter_idx = 5'd8;   8'h3B: letter_idx = 5'd9;
      8'h42: letter_idx = 5'd10;  8'h4B: letter_idx = 5'd11;
      8'h3A: letter_idx = 5'd12;  8'h31: letter_idx = 5'd13;
      8'h44: letter_idx = 5'd14;  8'h4D: letter_idx = 5'd15;
      8'h15: letter_idx = 5'd16;  8'h2D: letter_idx = 5'd17;
      8'h1B: letter_idx = 5'd18;  8'h2C: letter_idx = 5'd19;
      8'h3C: letter_idx = 5'd20;  8'h2A: letter_idx = 5'd21;
      8'h1D: letter_idx = 5'd22;  8'h22: letter_idx = 5'd23;
      8'h35: letter_idx = 5'd24;  8'h1A: letter_idx = 5'd25;
      default: is_letter = 1'b0;
    endcase
    is_sym   = 1'b1;
    sym_char = 8'h00;
    case (bus.PS2_code)
      8'h45: sym_char = 8'h30;  8'h16: sym_char = 8'h31;
      8'h1E: sym_char = 8'h32;  8'h26: sym_char = 8'h33;
      8'h25: sym_char = 8'h34;  8'h2E: sym_char = 8'h35;
      8'h36: sym_char = 8'h36;  8'h3D: sym_char = 8'h37;
      8'h3E: sym_char = 8'h38;  8'h46: sym_char = 8'h39;
      8'h29: sym_char = 8'h20;  8'h5A: sym_char = 8'h0D;
      8'h66: sym_char = 8'h08;
      default: is_sym = 1'b0;
    endcase
  end

  // Decoder next state: prefix tracking, shift flags and push request.
  always_comb begin
    state_d   = state_q;
    ls_d      = left_shift;
    rs_d      = right_shift;
    push_req  = 1'b0;
    push_char = 8'h00;
    if (code_evt) begin
      case (state_q)
        S_KEY_IDLE: begin
          if (bus.PS2_code == 8'hF0)      state_d = S_KEY_BREAK;
          else if (bus.PS2_code == 8'hE0) state_d = S_KEY_EXT;
          else if (bus.PS2_code == 8'h12) ls_d = 1'b1;
          else if (bus.PS2_code == 8'h59) rs_d = 1'b1;
          else if (is_letter) begin
            // Case comes from the shift state held before this event.
            push_req  = 1'b1;
            push_char = ((left_shift | right_shift) ? 8'h41 : 8'h61) + {3'b000, letter_idx};
          end else if (is_sym) begin
            push_req  = 1'b1;
            push_char = sym_char;
          end
        end
        S_KEY_BREAK: begin
          if (bus.PS2_code == 8'h12) ls_d = 1'b0;
          if (bus.PS2_code == 8'h59) rs_d = 1'b0;
          state_d = S_KEY_IDLE;
        end
        S_KEY_EXT:       state_d = (bus.PS2_code == 8'hF0) ? S_KEY_EXT_BREAK : S_KEY_IDLE;
        S_KEY_EXT_BREAK: state_d = S_KEY_IDLE;
        default:         state_d = S_KEY_IDLE;
      endcase
    end
  end

  // Decoder state and edge-detect registers.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= S_KEY_IDLE;
      ready_q     <= 1'b0;
      left_shift  <= 1'b0;
      right_shift <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= bus.PS2_code_ready;
      left_shift  <= ls_d;
      right_shift <= rs_d;
    end
  end

  assign full  = (count == DEPTH5);
  assign empty = (count == 5'd0);
  // A pop frees a slot on the same edge, so a full FIFO still accepts a push.
  assign do_pop  = bus.char_rd_en & ~empty;
  assign do_push = push_req & (~full | do_pop);

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 5'd0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      if (push_req && !do_push) overflow <= 1'b1;
    end
  end

  // Character storage; contents are don't-care until written.
  always_ff @(posedge Clock_50) begin
    if (do_push) mem[wr_ptr] <= push_char;
  end

  assign bus.char_data     = mem[rd_ptr];
  assign bus.char_empty    = empty;
  assign bus.char_full     = full;
  assign bus.char_count    = count;
  assign bus.char_overflow = overflow;
  assign bus.shift_active  = left_shift | right_shift;
endmodule

// File: tb/tb_ps2_key_fifo.sv
// Testbench for ps2_key_fifo: scan-code sequences are driven as ready-level
// frames; the characters each one should produce go into a scoreboard queue
// that is drained against the FIFO head.
module tb_ps2_key_fifo;
  localparam int DEPTH = 8;

  logic Clock_50 = 1'b0;
  logic Resetn   = 1'b0;
  ps2_key_fifo_if bus_if ();

  ps2_key_fifo #(.FIFO_DEPTH(DEPTH)) dut (
    .Clock_50 (Clock_50),
    .Resetn   (Resetn),
    .bus      (bus_if.slave)
  );

  always #5 Clock_50 = ~Clock_50;

  logic [7:0] q[$];
  bit         exp_ovf;
  int         checks = 0;
  int         errors = 0;

  // Reset with optional ready level held across release.
  task automatic do_reset(input logic rdy, input logic [7:0] code);
    @(negedge Clock_50);
    bus_if.PS2_code       = code;
    bus_if.PS2_code_ready = rdy;
    bus_if.char_rd_en     = 1'b0;
    Resetn = 1'b0;
    q.delete();
    exp_ovf = 0;
    repeat (2) @(negedge Clock_50);
    Resetn = 1'b1;
  endtask

  // One PS/2 frame: ready rises, holds, falls. Scoreboard updated when driven.
  task automatic send(input logic [7:0] code, input bit p, input logic [7:0] ch);
    @(negedge Clock_50);
    bus_if.PS2_code       = code;
    bus_if.PS2_code_ready = 1'b1;
    if (p) begin
      if (q.size() < DEPTH) q.push_back(ch);
      else exp_ovf = 1;
    end
    repeat (2) @(negedge Clock_50);
    bus_if.PS2_code_ready = 1'b0;
    repeat (2) @(negedge Clock_50);
  endtask

  task automatic pop_one();
    bus_if.char_rd_en = 1'b1;
    @(negedge Clock_50);
    bus_if.char_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0, 8'h00);
    @(negedge Clock_50);
    checks++; if (bus_if.char_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b want 1", bus_if.char_empty); end
    checks++; if (bus_if.char_full !== 1'b0) begin errors++; $display("FAIL rst_full got %b want 0", bus_if.char_full); end
    checks++; if (bus_if.char_count !== 5'd0) begin errors++; $display("FAIL rst_count got %0d want 0", bus_if.char_count); end
    checks++; if (bus_if.char_overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", bus_if.char_overflow); end
    checks++; if (bus_if.shift_active !== 1'b0) begin errors++; $display("FAIL rst_shift got %b want 0", bus_if.shift_active); end
  endtask

  task automatic test_basic();
    send(8'h1C, 1, 8'h61);
    send(8'h32, 1, 8'h62);
    checks++; if (bus_if.char_count !== 5'd2) begin errors++; $display("FAIL basic_count got %0d want 2", bus_if.char_count); end
    while (q.size() > 0) begin
      checks++; if (bus_if.char_data !== q[0]) begin errors++; $display("FAIL basic_data got %h want %h", bus_if.char_data, q[0]); end
      void'(q.pop_front());
      pop_one();
    end
    checks++; if (bus_if.char_empty !== 1'b1) begin errors++; $display("FAIL basic_empty got %b want 1", bus_if.char_empty); end
  endtask

  task automatic test_shift();
    send(8'h12, 0, 8'h00);
    checks++; if (bus_if.shift_active !== 1'b1) begin errors++; $display("FAIL shift_on got %b want 1", bus_if.shift_active); end
    send(8'h1C, 1, 8'h41);
    send(8'hF0, 0, 8'h00);
    checks++; if (bus_if.shift_active !== 1'b1) begin errors++; $display("FAIL shift_prefix got %b want 1", bus_if.shift_active); end
    send(8'h12, 0, 8'h00);
    checks++; if (bus_if.shift_active !== 1'b0) begin errors++; $display("FAIL shift_off got %b want 0", bus_if.shift_active); end
    send(8'h1C, 1, 8'h61);
    send(8'h59, 0, 8'h00);
    send(8'h1A, 1, 8'h5A);
    send(8'hF0, 0, 8'h00);
    send(8'h59, 0, 8'h00);
    checks++; if (bus_if.char_count !== 5'(q.size())) begin errors++; $display("FAIL shift_count got %0d want %0d", bus_if.char_count, q.size()); end
    while (q.size() > 0) begin
      checks++; if (bus_if.char_data !== q[0]) begin errors++; $display("FAIL shift_data got %h want %h", bus_if.char_data, q[0]); end
      void'(q.pop_front());
      pop_one();
    end
  endtask

  task automatic test_ext_and_symbols();
    send(8'hE0, 0, 8'h00); send(8'h75, 0, 8'h00);
    send(8'hE0, 0, 8'h00); send(8'hF0, 0, 8'h00); send(8'h75, 0, 8'h00);
    send(8'h45, 1, 8'h30);
    checks++; if (bus_if.char_count !== 5'd1) begin errors++; $display("FAIL ext_count got %0d want 1", bus_if.char_count); end
    send(8'h29, 1, 8'h20); send(8'h5A, 1, 8'h0D); send(8'h66, 1, 8'h08);
    send(8'h05, 0, 8'h00); send(8'h46, 1, 8'h39);
    send(8'hE0, 0, 8'h00); send(8'h12, 0, 8'h00);
    checks++; if (bus_if.shift_active !== 1'b0) begin errors++; $display("FAIL ext_shift got %b want 0", bus_if.shift_active); end
    checks++; if (bus_if.char_count !== 5'(q.size())) begin errors++; $display("FAIL sym_count got %0d want %0d", bus_if.char_count, q.size()); end
    while (q.size() > 0) begin
      checks++; if (bus_if.char_data !== q[0]) begin errors++; $display("FAIL sym_data got %h want %h", bus_if.char_data, q[0]); end
      void'(q.pop_front());
      pop_one();
    end
    pop_one();
    pop_one();
    checks++; if (bus_if.char_count !== 5'd0) begin errors++; $display("FAIL empty_pop got %0d want 0", bus_if.char_count); end
    send(8'h1C, 1, 8'h61);
    checks++; if (bus_if.char_data !== 8'h61) begin errors++; $display("FAIL after_empty_pop got %h want 61", bus_if.char_data); end
    void'(q.pop_front());
    pop_one();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 10; i++) begin
      send(8'h16, 1, 8'h31);
      if (i == 7) begin
        checks++; if (bus_if.char_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", bus_if.char_overflow); end
        checks++; if (bus_if.char_full !== 1'b1) begin errors++; $display("FAIL full_at8 got %b want 1", bus_if.char_full); end
      end
      if (i == 8) begin
        checks++; if (bus_if.char_overflow !== exp_ovf) begin errors++; $display("FAIL ovf_9th got %b want %b", bus_if.char_overflow, exp_ovf); end
      end
    end
    checks++; if (bus_if.char_count !== 5'(q.size())) begin errors++; $display("FAIL ovf_count got %0d want %0d", bus_if.char_count, q.size()); end
  endtask

  task automatic test_full_push_pop();
    @(negedge Clock_50);
    bus_if.PS2_code       = 8'h29;
    bus_if.PS2_code_ready = 1'b1;
    bus_if.char_rd_en     = 1'b1;
    void'(q.pop_front());
    q.push_back(8'h20);
    @(negedge Clock_50);
    bus_if.char_rd_en = 1'b0;
    @(negedge Clock_50);
    bus_if.PS2_code_ready = 1'b0;
    @(negedge Clock_50);
    checks++; if (bus_if.char_count !== 5'(DEPTH)) begin errors++; $display("FAIL fpp_count got %0d want %0d", bus_if.char_count, DEPTH); end
    checks++; if (bus_if.char_overflow !== exp_ovf) begin errors++; $display("FAIL fpp_ovf got %b want %b", bus_if.char_overflow, exp_ovf); end
    while (q.size() > 0) begin
      checks++; if (bus_if.char_data !== q[0]) begin errors++; $display("FAIL fpp_data got %h want %h", bus_if.char_data, q[0]); end
      void'(q.pop_front());
      pop_one();
    end
    checks++; if (bus_if.char_empty !== 1'b1) begin errors++; $display("FAIL fpp_empty got %b want 1", bus_if.char_empty); end
    checks++; if (bus_if.char_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", bus_if.char_overflow); end
  endtask

  task automatic test_hold_and_reset();
    // Long ready level: one push only.
    do_reset(1'b0, 8'h00);
    @(negedge Clock_50);
    bus_if.PS2_code       = 8'h1C;
    bus_if.PS2_code_ready = 1'b1;
    q.push_back(8'h61);
    repeat (100) @(negedge Clock_50);
    bus_if.PS2_code_ready = 1'b0;
    @(negedge Clock_50);
    checks++; if (bus_if.char_count !== 5'd1) begin errors++; $display("FAIL hold_count got %0d want 1", bus_if.char_count); end
    checks++; if (bus_if.char_overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared got %b want 0", bus_if.char_overflow); end
    // Reset after a break prefix discards it.
    send(8'hF0, 0, 8'h00);
    do_reset(1'b0, 8'h00);
    send(8'h1C, 1, 8'h61);
    checks++; if (bus_if.char_count !== 5'd1) begin errors++; $display("FAIL prefix_count got %0d want 1", bus_if.char_count); end
    checks++; if (bus_if.char_data !== q[0]) begin errors++; $display("FAIL prefix_data got %h want %h", bus_if.char_data, q[0]); end
    // Ready already high when reset releases counts as an event.
    do_reset(1'b1, 8'h32);
    q.push_back(8'h62);
    repeat (3) @(negedge Clock_50);
    bus_if.PS2_code_ready = 1'b0;
    @(negedge Clock_50);
    checks++; if (bus_if.char_count !== 5'd1) begin errors++; $display("FAIL rel_count got %0d want 1", bus_if.char_count); end
    checks++; if (bus_if.char_data !== q[0]) begin errors++; $display("FAIL rel_data got %h want %h", bus_if.char_data, q[0]); end
  endtask

  initial begin
    bus_if.PS2_code       = 8'h00;
    bus_if.PS2_code_ready = 1'b0;
    bus_if.char_rd_en     = 1'b0;
    exp_ovf = 0;
    test_reset();
    test_basic();
    test_shift();
    test_ext_and_symbols();
    test_overflow();
    test_full_push_pop();
    test_hold_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
